// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin 4:1 burst arbiter with a one-entry output stage.
// Define ARB_STATS_EN to add saturating per-requester grant counters.
module rr_mux_arbiter #(
   parameter int DATA_W    = 24,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req_valid,
   input  logic [3:0]        req_last,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   input  logic [DATA_W-1:0] req_data2,
   input  logic [DATA_W-1:0] req_data3,
   output logic [3:0]        req_ready,
   output logic [1:0]        grant_sel,
   output logic              grant_active,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]       burst_cnt0,
   output logic [15:0]       burst_cnt1,
   output logic [15:0]       burst_cnt2,
   output logic [15:0]       burst_cnt3
`endif
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [1:0]        r_grant_sel;
   logic [1:0]        r_last_grant;
   logic [1:0]        w_pick;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_out_valid;
   logic              r_out_last;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_busy;
   logic              w_out_free;
   logic              w_sel_valid;
   logic              w_sel_last;
   logic              w_xfer;
   logic              w_start;
   logic              w_release;
   logic [3:0]        w_ready;

   assign w_busy      = (r_state == S_BUSY);
   assign w_out_free  = !r_out_valid || out_ready;
   assign w_sel_valid = req_valid[r_grant_sel];
   assign w_sel_last  = req_last[r_grant_sel];
   assign w_ready     = (w_busy && w_out_free) ? (4'b0001 << r_grant_sel) : 4'b0000;
   assign w_xfer      = w_busy && w_out_free && w_sel_valid;

   assign req_ready    = w_ready;
   assign grant_sel    = r_grant_sel;
   assign grant_active = w_busy;
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_last     = r_out_last;

   // Round-robin pick: first valid requester after the last grantee
   always_comb begin
      w_pick = r_last_grant;
      for (int k = 4; k >= 1; k--) begin
         if (req_valid[r_last_grant + 2'(k)]) begin
            w_pick = r_last_grant + 2'(k);
         end
      end
   end

   // Shared word mux steered by the current grant
   always_comb begin
      w_sel_data = req_data0;
      unique case (r_grant_sel)
         2'd0: w_sel_data = req_data0;
         2'd1: w_sel_data = req_data1;
         2'd2: w_sel_data = req_data2;
         2'd3: w_sel_data = req_data3;
      endcase
   end

   // Next-state: grant from IDLE, release on last beat or burst cap
   always_comb begin
      w_state_nx = r_state;
      w_start    = 1'b0;
      w_release  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (|req_valid) begin
               w_start    = 1'b1;
               w_state_nx = S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_xfer && (w_sel_last || (r_cnt == CAP_LAST))) begin
               w_release  = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Grant bookkeeping; last_grant=3 makes requester 0 first after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant_sel  <= 2'd0;
         r_last_grant <= 2'd3;
      end else if (w_start) begin
         r_grant_sel  <= w_pick;
         r_last_grant <= w_pick;
      end
   end

   // Beats moved in the current burst
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_start) begin
         r_cnt <= '0;
      end else if (w_xfer && !w_release) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // One-entry output stage; data and last hold until replaced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_last  <= w_sel_last;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] r_burst_cnt [4];

   // Grants per requester, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_burst_cnt[i] <= '0;
         end
      end else if (w_start && (r_burst_cnt[w_pick] != 16'hFFFF)) begin
         r_burst_cnt[w_pick] <= r_burst_cnt[w_pick] + 16'd1;
      end
   end

   assign burst_cnt0 = r_burst_cnt[0];
   assign burst_cnt1 = r_burst_cnt[1];
   assign burst_cnt2 = r_burst_cnt[2];
   assign burst_cnt3 = r_burst_cnt[3];
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed bursts with a scoreboard on the output words
// and a second scoreboard on the grant order.
module tb_rr_mux_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = 4'b0;
   logic [3:0]  req_last = 4'b0;
   logic [23:0] req_data0 = '0;
   logic [23:0] req_data1 = '0;
   logic [23:0] req_data2 = '0;
   logic [23:0] req_data3 = '0;
   logic [3:0]  req_ready;
   logic [1:0]  grant_sel;
   logic        grant_active;
   logic        out_valid;
   logic [23:0] out_data;
   logic        out_last;
   logic        out_ready = 1'b1;
`ifdef ARB_STATS_EN
   logic [15:0] burst_cnt0, burst_cnt1, burst_cnt2, burst_cnt3;
`endif

   rr_mux_arbiter #(.DATA_W(24), .MAX_BURST(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_data0    (req_data0),
      .req_data1    (req_data1),
      .req_data2    (req_data2),
      .req_data3    (req_data3),
      .req_ready    (req_ready),
      .grant_sel    (grant_sel),
      .grant_active (grant_active),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready)
`ifdef ARB_STATS_EN
      ,
      .burst_cnt0   (burst_cnt0),
      .burst_cnt1   (burst_cnt1),
      .burst_cnt2   (burst_cnt2),
      .burst_cnt3   (burst_cnt3)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // per-requester beat queues: {last, data}
   logic [24:0] q0[$];
   logic [24:0] q1[$];
   logic [24:0] q2[$];
   logic [24:0] q3[$];
   // expected output words and expected grant order
   logic [24:0] eq[$];
   logic [1:0]  gq[$];

   bit gap_en = 0;
   bit seen_g = 0;
   int idle_n = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic logic [24:0] bt(input logic l, input logic [23:0] d);
      return {l, d};
   endfunction

   // requester driver: pop accepted beats, present queue heads
   initial begin
      logic [3:0] hs;
      forever begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         if (hs[0] && q0.size() > 0) void'(q0.pop_front());
         if (hs[1] && q1.size() > 0) void'(q1.pop_front());
         if (hs[2] && q2.size() > 0) void'(q2.pop_front());
         if (hs[3] && q3.size() > 0) void'(q3.pop_front());
         req_valid = 4'b0;
         req_last  = 4'b0;
         if (q0.size() > 0) begin
            req_valid[0] = 1'b1; req_last[0] = q0[0][24]; req_data0 = q0[0][23:0];
         end
         if (q1.size() > 0) begin
            req_valid[1] = 1'b1; req_last[1] = q1[0][24]; req_data1 = q1[0][23:0];
         end
         if (q2.size() > 0) begin
            req_valid[2] = 1'b1; req_last[2] = q2[0][24]; req_data2 = q2[0][23:0];
         end
         if (q3.size() > 0) begin
            req_valid[3] = 1'b1; req_last[3] = q3[0][24]; req_data3 = q3[0][23:0];
         end
      end
   end

   // output monitor: every accepted word against the expected queue
   initial begin
      logic [24:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (eq.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL out_unexpected act=%h exp=none", {out_last, out_data});
            end else begin
               e = eq.pop_front();
               chk("out_word", 32'({out_last, out_data}), 32'(e));
            end
         end
      end
   end

   // grant monitor: order of grants and IDLE gap between them
   initial begin
      bit prev = 0;
      forever begin
         @(negedge clk);
         if (rst_n && grant_active && !prev) begin
            if (gq.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL grant_unexpected act=%0d exp=none", grant_sel);
            end else begin
               chk("grant_order", 32'(grant_sel), 32'(gq.pop_front()));
            end
            if (gap_en && seen_g) chk("idle_gap", 32'(idle_n), 32'd1);
            seen_g = 1;
            idle_n = 0;
         end else if (!grant_active) begin
            idle_n++;
         end
         prev = grant_active;
      end
   end

   task automatic clear_all();
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      eq.delete(); gq.delete();
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_grant_sel", 32'(grant_sel), 32'd0);
      chk("rst_grant_active", 32'(grant_active), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      clear_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen_g = 0;
      idle_n = 0;
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while ((eq.size() > 0 || gq.size() > 0 || q0.size() > 0 ||
              q1.size() > 0 || q2.size() > 0 || q3.size() > 0 ||
              grant_active || out_valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(n < 400), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // single burst on requester 2
      do_reset();
      @(negedge clk);
      q2.push_back(bt(0, 24'h00000A));
      q2.push_back(bt(0, 24'h00000B));
      q2.push_back(bt(1, 24'h00000C));
      eq.push_back(bt(0, 24'h00000A));
      eq.push_back(bt(0, 24'h00000B));
      eq.push_back(bt(1, 24'h00000C));
      gq.push_back(2'd2);
      @(negedge clk);
      chk("sb_idle_t", 32'(grant_active), 32'd0);
      @(negedge clk);
      chk("sb_grant_sel", 32'(grant_sel), 32'd2);
      chk("sb_grant_active", 32'(grant_active), 32'd1);
      chk("sb_req_ready", 32'(req_ready), 32'b0100);
      chk("sb_out_valid_t1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("sb_out_valid_t2", 32'(out_valid), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("sb_idle_t4", 32'(grant_active), 32'd0);
      chk("sb_last_t4", 32'(out_last), 32'd1);
      wait_drain("sb_drain");

      // fairness: all four requesters, 1-beat bursts, two rounds
      do_reset();
      gap_en = 1;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            logic [24:0] b;
            b = bt(1, 24'(32'h100 * (r + 1) + i));
            case (i)
               0: q0.push_back(b);
               1: q1.push_back(b);
               2: q2.push_back(b);
               default: q3.push_back(b);
            endcase
            eq.push_back(b);
            gq.push_back(2'(i));
         end
      end
      wait_drain("fair_drain");
      gap_en = 0;

      // burst cap: requester 1 sends 10 beats, requester 2 waits
      do_reset();
      @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         q1.push_back(bt(k == 10, 24'(32'h1000 + k)));
      end
      q2.push_back(bt(1, 24'h002222));
      for (int k = 1; k <= 8; k++) eq.push_back(bt(0, 24'(32'h1000 + k)));
      eq.push_back(bt(1, 24'h002222));
      eq.push_back(bt(0, 24'h00100A - 24'h1));
      eq.push_back(bt(1, 24'h00100A));
      gq.push_back(2'd1);
      gq.push_back(2'd2);
      gq.push_back(2'd1);
      wait_drain("cap_drain");

      // backpressure with 0x123456 pending
      do_reset();
      @(negedge clk);
      q3.push_back(bt(0, 24'h111111));
      q3.push_back(bt(0, 24'h123456));
      q3.push_back(bt(0, 24'h333333));
      q3.push_back(bt(1, 24'h444444));
      eq.push_back(bt(0, 24'h111111));
      eq.push_back(bt(0, 24'h123456));
      eq.push_back(bt(0, 24'h333333));
      eq.push_back(bt(1, 24'h444444));
      gq.push_back(2'd3);
      n = 0;
      while (!(out_valid && out_data == 24'h123456) && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("bp_reach", 32'(n < 50), 32'd1);
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", 32'(out_data), 32'h123456);
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      wait_drain("bp_drain");

      // async reset in the middle of a requester 0 burst
      do_reset();
      @(negedge clk);
      for (int k = 1; k <= 6; k++) q0.push_back(bt(k == 6, 24'(32'h0A0000 + k)));
      for (int k = 1; k <= 3; k++) eq.push_back(bt(0, 24'(32'h0A0000 + k)));
      gq.push_back(2'd0);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_req_ready", 32'(req_ready), 32'd0);
      chk("ar_grant_active", 32'(grant_active), 32'd0);
      chk("ar_words_seen", 32'(eq.size()), 32'd0);
      clear_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q3.push_back(bt(1, 24'h000303));
      q2.push_back(bt(1, 24'h000202));
      q1.push_back(bt(1, 24'h000101));
      q0.push_back(bt(1, 24'h000001));
      eq.push_back(bt(1, 24'h000001));
      eq.push_back(bt(1, 24'h000101));
      eq.push_back(bt(1, 24'h000202));
      eq.push_back(bt(1, 24'h000303));
      gq.push_back(2'd0);
      gq.push_back(2'd1);
      gq.push_back(2'd2);
      gq.push_back(2'd3);
      wait_drain("ar_drain");

`ifdef ARB_STATS_EN
      // five single-beat grants to requester 3
      do_reset();
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         q3.push_back(bt(1, 24'(32'h30 + k)));
         eq.push_back(bt(1, 24'(32'h30 + k)));
         gq.push_back(2'd3);
      end
      wait_drain("st_drain");
      chk("st_cnt3", 32'(burst_cnt3), 32'd5);
      chk("st_cnt0", 32'(burst_cnt0), 32'd0);
      chk("st_cnt1", 32'(burst_cnt1), 32'd0);
      chk("st_cnt2", 32'(burst_cnt2), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
